// File: rtl/bus_sequencer_if.sv
// Signal bundle between bus_sequencer and its CPU, video, host and memory-bus neighbours.
// Completion strobes (cpu_done, video_valid, host_ack) are single-cycle pulses with their data
// valid in the same cycle; host_req is level-sensitive and sampled only at a HOST slot start edge.
interface bus_sequencer_if;
  logic [15:0] cpu_addr;
  logic        cpu_rw_b;
  logic [7:0]  cpu_wr_data;
  logic        cpu_done;
  logic [7:0]  cpu_rd_data;

  logic [16:0] video_addr;
  logic        video_valid;
  logic [7:0]  video_data;

  logic        host_req;
  logic [16:0] host_addr;
  logic        host_rw_b;
  logic [7:0]  host_wr_data;
  logic        host_ack;
  logic [7:0]  host_rd_data;

  logic [16:0] addr;
  logic        rw_b;
  logic        strobe;
  logic [7:0]  bus_wr_data;
  logic [7:0]  bus_rd_data;

  logic [2:0]  seq_state;

  modport master (
    input  cpu_addr, cpu_rw_b, cpu_wr_data,
    output cpu_done, cpu_rd_data,
    input  video_addr,
    output video_valid, video_data,
    input  host_req, host_addr, host_rw_b, host_wr_data,
    output host_ack, host_rd_data,
    output addr, rw_b, strobe, bus_wr_data,
    input  bus_rd_data,
    output seq_state
  );

  modport slave (
    output cpu_addr, cpu_rw_b, cpu_wr_data,
    input  cpu_done, cpu_rd_data,
    output video_addr,
    input  video_valid, video_data,
    output host_req, host_addr, host_rw_b, host_wr_data,
    input  host_ack, host_rd_data,
    input  addr, rw_b, strobe, bus_wr_data,
    output bus_rd_data,
    input  seq_state
  );
endinterface

// File: rtl/bus_sequencer.sv
// Time-sliced bus owner: repeating frame of 2-cycle slots CPU, [VIDEO,] HOST.
// Define VIDEO_SLOT_EN to include the VIDEO slot; otherwise the frame is CPU, HOST.
module bus_sequencer (
  input  logic            clk,
  input  logic            reset,
  bus_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CPU0  = 3'd1,
    S_CPU1  = 3'd2,
    S_VID0  = 3'd3,
    S_VID1  = 3'd4,
    S_HOST0 = 3'd5,
    S_HOST1 = 3'd6
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic        slot_start;
  logic [16:0] addr_d;
  logic        rw_b_d;
  logic        strobe_d;
  logic [7:0]  wr_data_d;
  logic        host_live_d;

  logic [16:0] addr_q;
  logic        rw_b_q;
  logic        strobe_q;
  logic [7:0]  wr_data_q;
  logic        host_live_q;

  logic        cpu_done_q;
  logic [7:0]  cpu_rd_q;
  logic        host_ack_q;
  logic [7:0]  host_rd_q;

  // State names the cycle being executed; S_IDLE exists only so the first edge out of reset starts CPU.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_CPU0;
    case (state_q)
      S_IDLE:  state_d = S_CPU0;
      S_CPU0:  state_d = S_CPU1;
`ifdef VIDEO_SLOT_EN
      S_CPU1:  state_d = S_VID0;
      S_VID0:  state_d = S_VID1;
      S_VID1:  state_d = S_HOST0;
`else
      S_CPU1:  state_d = S_HOST0;
`endif
      S_HOST0: state_d = S_HOST1;
      S_HOST1: state_d = S_CPU0;
      default: state_d = S_CPU0;
    endcase
  end

  // Bus request for the slot about to begin; loaded only on a slot start edge and held for both cycles.
  always_comb begin
    slot_start  = 1'b0;
    addr_d      = 17'h0;
    rw_b_d      = 1'b1;
    strobe_d    = 1'b0;
    wr_data_d   = 8'h00;
    host_live_d = 1'b0;
    case (state_d)
      S_CPU0: begin
        slot_start = 1'b1;
        addr_d     = {1'b0, bus.cpu_addr};
        rw_b_d     = bus.cpu_rw_b;
        strobe_d   = 1'b1;
        wr_data_d  = bus.cpu_rw_b ? 8'h00 : bus.cpu_wr_data;
      end
`ifdef VIDEO_SLOT_EN
      S_VID0: begin
        slot_start = 1'b1;
        addr_d     = bus.video_addr;
        strobe_d   = 1'b1;
      end
`endif
      S_HOST0: begin
        slot_start = 1'b1;
        if (bus.host_req) begin
          addr_d      = bus.host_addr;
          rw_b_d      = bus.host_rw_b;
          strobe_d    = 1'b1;
          wr_data_d   = bus.host_rw_b ? 8'h00 : bus.host_wr_data;
          host_live_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= 17'h0;
      rw_b_q      <= 1'b1;
      strobe_q    <= 1'b0;
      wr_data_q   <= 8'h00;
      host_live_q <= 1'b0;
    end else if (slot_start) begin
      addr_q      <= addr_d;
      rw_b_q      <= rw_b_d;
      strobe_q    <= strobe_d;
      wr_data_q   <= wr_data_d;
      host_live_q <= host_live_d;
    end
  end

  // Completion: the edge leaving an X1 state ends the slot and samples the read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_done_q <= 1'b0;
      cpu_rd_q   <= 8'h00;
      host_ack_q <= 1'b0;
      host_rd_q  <= 8'h00;
    end else begin
      cpu_done_q <= (state_q == S_CPU1);
      if ((state_q == S_CPU1) && rw_b_q) cpu_rd_q <= bus.bus_rd_data;
      host_ack_q <= (state_q == S_HOST1) && host_live_q;
      if ((state_q == S_HOST1) && host_live_q && rw_b_q) host_rd_q <= bus.bus_rd_data;
    end
  end

`ifdef VIDEO_SLOT_EN
  logic       video_valid_q;
  logic [7:0] video_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      video_valid_q <= 1'b0;
      video_data_q  <= 8'h00;
    end else begin
      video_valid_q <= (state_q == S_VID1);
      if (state_q == S_VID1) video_data_q <= bus.bus_rd_data;
    end
  end

  assign bus.video_valid = video_valid_q;
  assign bus.video_data  = video_data_q;
`else
  logic unused_video;
  assign unused_video    = ^bus.video_addr;
  assign bus.video_valid = 1'b0;
  assign bus.video_data  = 8'h00;
`endif

  assign bus.addr         = addr_q;
  assign bus.rw_b         = rw_b_q;
  assign bus.strobe       = strobe_q;
  assign bus.bus_wr_data  = wr_data_q;
  assign bus.cpu_done     = cpu_done_q;
  assign bus.cpu_rd_data  = cpu_rd_q;
  assign bus.host_ack     = host_ack_q;
  assign bus.host_rd_data = host_rd_q;
  assign bus.seq_state    = state_q;

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed bench for bus_sequencer; frame length follows VIDEO_SLOT_EN.
module tb_bus_sequencer;

`ifdef VIDEO_SLOT_EN
  localparam int FRAME = 6;
`else
  localparam int FRAME = 4;
`endif

  logic clk;
  logic reset;
  int   n_asserts;
  int   n_fail;
  int   n_ack;
  int   n_vid;
  int   last_ack;
  int   pos;

  bus_sequencer_if bus ();

  bus_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered in the VID0 cycle, returns in the HOST0 cycle.
  task automatic video_slot();
`ifdef VIDEO_SLOT_EN
    chk("vid_addr", bus.addr, 17'h08000);
    chk("vid_rw_b", bus.rw_b, 1);
    chk("vid_strobe", bus.strobe, 1);
    chk("vid_wr_data", bus.bus_wr_data, 0);
    bus.bus_rd_data = 8'h41;
    tick();
    chk("vid_valid_early", bus.video_valid, 0);
    chk("vid_addr_hold", bus.addr, 17'h08000);
    tick();
    chk("vid_valid", bus.video_valid, 1);
    chk("vid_data", bus.video_data, 8'h41);
`endif
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    reset     = 1'b1;
    bus.cpu_addr     = 16'h0;
    bus.cpu_rw_b     = 1'b1;
    bus.cpu_wr_data  = 8'h00;
    bus.video_addr   = 17'h08000;
    bus.host_req     = 1'b0;
    bus.host_addr    = 17'h0;
    bus.host_rw_b    = 1'b1;
    bus.host_wr_data = 8'h00;
    bus.bus_rd_data  = 8'h00;
    repeat (3) tick();

    chk("rst_addr", bus.addr, 0);
    chk("rst_rw_b", bus.rw_b, 1);
    chk("rst_strobe", bus.strobe, 0);
    chk("rst_wr_data", bus.bus_wr_data, 0);
    chk("rst_cpu_done", bus.cpu_done, 0);
    chk("rst_video_valid", bus.video_valid, 0);
    chk("rst_host_ack", bus.host_ack, 0);
    chk("rst_cpu_rd", bus.cpu_rd_data, 0);
    chk("rst_host_rd", bus.host_rd_data, 0);
    chk("rst_video_data", bus.video_data, 0);

    // Frame 1: CPU read of 0x1234, idle HOST slot
    bus.cpu_addr    = 16'h1234;
    bus.cpu_rw_b    = 1'b1;
    bus.cpu_wr_data = 8'h77;
    reset = 1'b0;
    tick();
    chk("cpu1_addr", bus.addr, 17'h01234);
    chk("cpu1_strobe", bus.strobe, 1);
    chk("cpu1_rw_b", bus.rw_b, 1);
    chk("cpu1_rd_wr_data", bus.bus_wr_data, 0);
    bus.bus_rd_data = 8'h3C;
    tick();
    chk("cpu2_addr_hold", bus.addr, 17'h01234);
    chk("cpu2_strobe_hold", bus.strobe, 1);
    chk("cpu2_done_early", bus.cpu_done, 0);
    tick();
    chk("cpu3_done", bus.cpu_done, 1);
    chk("cpu3_rd_data", bus.cpu_rd_data, 8'h3C);
    video_slot();
    chk("idle_strobe", bus.strobe, 0);
    chk("idle_addr", bus.addr, 0);
    chk("idle_rw_b", bus.rw_b, 1);
    chk("idle_wr_data", bus.bus_wr_data, 0);
    bus.cpu_addr    = 16'hC0DE;
    bus.cpu_rw_b    = 1'b0;
    bus.cpu_wr_data = 8'h99;
    tick();
    chk("idle2_ack", bus.host_ack, 0);
    chk("cpu_done_one_pulse", bus.cpu_done, 0);

    // Frame 2: CPU write, HOST write to 0x1E810 with inputs changed mid-slot
    bus.host_req     = 1'b1;
    bus.host_addr    = 17'h1E810;
    bus.host_rw_b    = 1'b0;
    bus.host_wr_data = 8'hA5;
    tick();
    chk("idle_no_ack", bus.host_ack, 0);
    chk("cpuw_addr", bus.addr, 17'h0C0DE);
    chk("cpuw_rw_b", bus.rw_b, 0);
    chk("cpuw_wr_data", bus.bus_wr_data, 8'h99);
    chk("cpuw_strobe", bus.strobe, 1);
    bus.bus_rd_data = 8'hEE;
    tick();
    tick();
    chk("cpuw_done", bus.cpu_done, 1);
    chk("cpuw_rd_kept", bus.cpu_rd_data, 8'h3C);
    video_slot();
    chk("hw_addr", bus.addr, 17'h1E810);
    chk("hw_rw_b", bus.rw_b, 0);
    chk("hw_wr_data", bus.bus_wr_data, 8'hA5);
    chk("hw_strobe", bus.strobe, 1);
    bus.host_req     = 1'b0;
    bus.host_addr    = 17'h00001;
    bus.host_wr_data = 8'h00;
    bus.host_rw_b    = 1'b1;
    tick();
    chk("hw_addr_hold", bus.addr, 17'h1E810);
    chk("hw_rw_b_hold", bus.rw_b, 0);
    chk("hw_wr_hold", bus.bus_wr_data, 8'hA5);
    chk("hw_ack_early", bus.host_ack, 0);
    tick();
    chk("hw_ack", bus.host_ack, 1);
    chk("hw_rd_kept", bus.host_rd_data, 0);
    tick();
    chk("hw_ack_one_pulse", bus.host_ack, 0);

    // Frames 3-5: host_req held high with reads, back-to-back
    bus.cpu_rw_b     = 1'b1;
    bus.host_req     = 1'b1;
    bus.host_rw_b    = 1'b1;
    bus.host_addr    = 17'h00100;
    bus.bus_rd_data  = 8'hC3;
    n_ack    = 0;
    n_vid    = 0;
    last_ack = -1;
    for (int k = 1; k <= 3 * FRAME; k++) begin
      tick();
      if (bus.video_valid === 1'b1) n_vid++;
      if (bus.host_ack === 1'b1) begin
        n_ack++;
        chk("b2b_rd_data", bus.host_rd_data, 8'hC3);
        if (last_ack >= 0) chk("b2b_spacing", k - last_ack, FRAME);
        last_ack = k;
      end
    end
    bus.host_req = 1'b0;
    chk("b2b_ack_count", n_ack, 3);
    chk("cpu_rd_loop", bus.cpu_rd_data, 8'hC3);
`ifdef VIDEO_SLOT_EN
    chk("video_pulse_count", n_vid, 3);
    chk("video_data_loop", bus.video_data, 8'hC3);
`else
    chk("video_pulse_count", n_vid, 0);
    chk("video_data_tied", bus.video_data, 0);
`endif

    // Frame 6: host idle for a whole frame
    for (int k = 1; k <= FRAME; k++) begin
      tick();
      pos = (1 + k) % FRAME;
      chk("idlef_ack", bus.host_ack, 0);
      if (pos >= FRAME - 2) begin
        chk("idlef_strobe", bus.strobe, 0);
        chk("idlef_addr", bus.addr, 0);
        chk("idlef_rw_b", bus.rw_b, 1);
      end
    end

    // Frame 7: reset in the second cycle of a HOST write
    bus.host_req     = 1'b1;
    bus.host_rw_b    = 1'b0;
    bus.host_addr    = 17'h00042;
    bus.host_wr_data = 8'h11;
    repeat (FRAME - 3) tick();
    chk("hr_strobe", bus.strobe, 1);
    chk("hr_rw_b", bus.rw_b, 0);
    chk("hr_addr", bus.addr, 17'h00042);
    chk("hr_wr_data", bus.bus_wr_data, 8'h11);
    tick();
    reset = 1'b1;
    tick();
    chk("abort_ack", bus.host_ack, 0);
    chk("abort_strobe", bus.strobe, 0);
    chk("abort_addr", bus.addr, 0);
    chk("abort_rw_b", bus.rw_b, 1);
    chk("abort_wr_data", bus.bus_wr_data, 0);
    chk("abort_cpu_rd", bus.cpu_rd_data, 0);
    chk("abort_host_rd", bus.host_rd_data, 0);
    chk("abort_cpu_done", bus.cpu_done, 0);
    bus.host_req = 1'b0;
    bus.cpu_addr = 16'h0ABC;
    bus.cpu_rw_b = 1'b1;
    reset = 1'b0;
    tick();
    chk("rel_cpu_addr", bus.addr, 17'h00ABC);
    chk("rel_cpu_strobe", bus.strobe, 1);
    chk("rel_cpu_rw_b", bus.rw_b, 1);
    for (int k = 1; k <= FRAME; k++) begin
      tick();
      chk("dropped_no_ack", bus.host_ack, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
